// File: rtl/vga_frame_monitor.sv
// Locks to incoming VGA timing, reports active pixels and a per-frame RGB checksum,
// and raises a sticky flag on any sync-timing violation.
module vga_frame_monitor #(
    parameter int H_TOTAL  = 800,
    parameter int V_TOTAL  = 525,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_en,
    input  logic        clear,
    input  logic        vga_hs,
    input  logic        vga_vs,
    input  logic        vga_blank_n,
    input  logic [7:0]  vga_r,
    input  logic [7:0]  vga_g,
    input  logic [7:0]  vga_b,
    output logic        locked,
    output logic        sync_err,
    output logic        frame_done,
    output logic        pix_valid,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic [23:0] pix_rgb,
    output logic [15:0] checksum
);

    localparam logic [1:0] S_SEARCH  = 2'd0;
    localparam logic [1:0] S_MEASURE = 2'd1;
    localparam logic [1:0] S_LOCKED  = 2'd2;

    logic [1:0]  state, next_state;
    logic        hs_d, vs_d, phase_ok;
    logic [10:0] h_cnt;
    logic [9:0]  line_cnt, act_x, act_y;
    logic [15:0] sum;

    logic        hs_fall, vs_fall, checking;
    logic        len_ok, ax_ok, hs_bad, vs_bad, h_sat, violation;
    logic        enter_measure, good_frame;
    logic [9:0]  ax_cur, ax_next, act_y_fin, line_cnt_fin;
    logic [9:0]  rgb_add;
    logic [15:0] sum_add;

    assign hs_fall  = hs_d & ~vga_hs;
    assign vs_fall  = vs_d & ~vga_vs;
    assign checking = (state != S_SEARCH);

    assign h_sat  = (h_cnt == 11'h7FF);
    assign len_ok = (({1'b0, h_cnt} + 12'd1) == 12'(H_TOTAL));
    assign ax_ok  = (act_x == 10'd0) || (act_x == 10'(H_ACTIVE));
    // The first hs fall after a (re)start closes a line of unknown length, so it only aligns phase.
    assign hs_bad = hs_fall && phase_ok && !(len_ok && ax_ok);

    assign line_cnt_fin = (hs_fall && line_cnt != 10'h3FF) ? line_cnt + 10'd1 : line_cnt;
    assign act_y_fin    = (hs_fall && act_x != 10'd0 && act_y != 10'h3FF) ? act_y + 10'd1 : act_y;
    assign vs_bad       = vs_fall && ((line_cnt_fin != 10'(V_TOTAL)) || (act_y_fin != 10'(V_ACTIVE)));

    assign violation     = checking && (h_sat || hs_bad || vs_bad);
    assign enter_measure = vs_fall && (state == S_SEARCH || violation);
    assign good_frame    = vs_fall && checking && !violation;

    assign ax_cur  = hs_fall ? 10'd0 : act_x;
    assign ax_next = (ax_cur != 10'h3FF) ? ax_cur + {9'd0, vga_blank_n} : ax_cur;
    assign rgb_add = {2'b00, vga_r} + {2'b00, vga_g} + {2'b00, vga_b};
    assign sum_add = sum + (vga_blank_n ? {6'd0, rgb_add} : 16'd0);

    always_comb begin
        next_state = state;
        if (violation) begin
            next_state = vs_fall ? S_MEASURE : S_SEARCH;
        end else if (vs_fall) begin
            next_state = (state == S_SEARCH) ? S_MEASURE : S_LOCKED;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_SEARCH;
            hs_d       <= 1'b1;
            vs_d       <= 1'b1;
            phase_ok   <= 1'b0;
            h_cnt      <= 11'd0;
            line_cnt   <= 10'd0;
            act_x      <= 10'd0;
            act_y      <= 10'd0;
            sum        <= 16'd0;
            locked     <= 1'b0;
            sync_err   <= 1'b0;
            frame_done <= 1'b0;
            pix_valid  <= 1'b0;
            x          <= 10'd0;
            y          <= 10'd0;
            pix_rgb    <= 24'd0;
            checksum   <= 16'd0;
        end else begin
            frame_done <= 1'b0;
            pix_valid  <= 1'b0;
            if (pix_en) begin
                state <= next_state;
                hs_d  <= vga_hs;
                vs_d  <= vga_vs;
                h_cnt <= hs_fall ? 11'd0 : (h_sat ? h_cnt : h_cnt + 11'd1);
                act_x <= ax_next;

                if (enter_measure) begin
                    phase_ok <= 1'b0;
                end else if (hs_fall) begin
                    phase_ok <= 1'b1;
                end

                // The sum is published before it clears, so the closing sample is included.
                if (vs_fall) begin
                    line_cnt <= 10'd0;
                    act_y    <= 10'd0;
                    sum      <= 16'd0;
                end else begin
                    line_cnt <= line_cnt_fin;
                    act_y    <= act_y_fin;
                    sum      <= sum_add;
                end

                if (state == S_LOCKED && vga_blank_n) begin
                    pix_valid <= 1'b1;
                    x         <= ax_cur;
                    y         <= act_y_fin;
                    pix_rgb   <= {vga_r, vga_g, vga_b};
                end

                locked <= (next_state == S_LOCKED);
                if (good_frame) begin
                    frame_done <= 1'b1;
                    checksum   <= sum_add;
                end
            end

            if (pix_en && violation) begin
                sync_err <= 1'b1;
            end else if (clear) begin
                sync_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vga_frame_monitor.sv
// Scoreboard bench for vga_frame_monitor on a scaled-down raster (24x14 total, 16x10 active).
module tb_vga_frame_monitor;

    localparam int HT = 24;
    localparam int HA = 16;
    localparam int VT = 14;
    localparam int VA = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        pix_en, clear;
    logic        vga_hs, vga_vs, vga_blank_n;
    logic [7:0]  vga_r, vga_g, vga_b;
    logic        locked, sync_err, frame_done, pix_valid;
    logic [9:0]  x, y;
    logic [23:0] pix_rgb;
    logic [15:0] checksum;

    vga_frame_monitor #(
        .H_TOTAL(HT), .V_TOTAL(VT), .H_ACTIVE(HA), .V_ACTIVE(VA)
    ) dut (
        .clk(clk), .reset(reset), .pix_en(pix_en), .clear(clear),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .locked(locked), .sync_err(sync_err), .frame_done(frame_done),
        .pix_valid(pix_valid), .x(x), .y(y), .pix_rgb(pix_rgb), .checksum(checksum)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    logic [43:0] pq[$];
    logic [15:0] cq[$];

    int          m_state;      // 0 search, 1 measure, 2 locked
    logic        m_err;
    logic [15:0] m_sum;
    int          lines_since;
    bit          short_pend;
    bit          gaps;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (pix_valid) begin
            if (pq.size() == 0) check_eq("pix_unexpected", 1, 0);
            else check_eq("pix", {20'd0, x, y, pix_rgb}, {20'd0, pq.pop_front()});
        end
        if (frame_done) begin
            if (cq.size() == 0) check_eq("done_unexpected", 1, 0);
            else check_eq("checksum", {48'd0, checksum}, {48'd0, cq.pop_front()});
        end
    end

    task automatic check_all_zero();
        check_eq("rst_locked", locked, 0);
        check_eq("rst_sync_err", sync_err, 0);
        check_eq("rst_frame_done", frame_done, 0);
        check_eq("rst_pix_valid", pix_valid, 0);
        check_eq("rst_x", x, 0);
        check_eq("rst_y", y, 0);
        check_eq("rst_rgb", pix_rgb, 0);
        check_eq("rst_checksum", checksum, 0);
    endtask

    task automatic model_reset();
        m_state = 0; m_err = 0; m_sum = 0; lines_since = 0; short_pend = 0;
        pq.delete(); cq.delete();
    endtask

    task automatic do_reset();
        pix_en = 0; clear = 0;
        vga_hs = 1; vga_vs = 1; vga_blank_n = 0;
        vga_r = 0; vga_g = 0; vga_b = 0;
        reset = 1;
        @(negedge clk);
        check_all_zero();
        reset = 0;
        @(negedge clk);
        model_reset();
    endtask

    task automatic drive_pix(input logic hs, input logic vs, input logic bl,
                             input logic [23:0] rgb, input logic clr);
        if (gaps) begin
            repeat ($urandom_range(0, 3)) begin
                pix_en = 0; clear = 0;
                @(negedge clk);
            end
        end
        vga_hs = hs; vga_vs = vs; vga_blank_n = bl;
        {vga_r, vga_g, vga_b} = rgb;
        clear = clr; pix_en = 1;
        @(posedge clk);
        @(negedge clk);
        pix_en = 0; clear = 0;
        check_eq("locked", locked, (m_state == 2));
        check_eq("sync_err", sync_err, m_err);
    endtask

    // color: 0 const 0x010203, 1 black, 2 random, 3 coordinate pattern
    task automatic drive_frame(input int n_lines, input int short_line, input int rst_line,
                               input int color, input bit clr_first, input bit clr_vs);
        logic [23:0] rgb;
        logic        hs, vs, bl, hsf, vsf, clr;
        for (int v = 0; v < n_lines; v++) begin
            if (v == rst_line) begin
                check_eq("pending_before_reset", pq.size(), 0);
                do_reset();
            end
            for (int h = 0; h < HT; h++) begin
                if (v == short_line && h == HT - 1) begin
                    short_pend = 1;
                    continue;
                end
                hs  = !(h >= 18 && h <= 21);
                vs  = !(v == 11 || v == 12);
                bl  = (h < HA) && (v < VA);
                hsf = (h == 18);
                vsf = (v == 11) && (h == 0);
                clr = (clr_first && v == 0 && h == 0) || (clr_vs && vsf);
                case (color)
                    0:       rgb = 24'h010203;
                    1:       rgb = 24'h000000;
                    2:       rgb = 24'($urandom);
                    default: rgb = {8'(h) ^ 8'h5A, 8'(v), 8'hC3};
                endcase
                if (bl && m_state == 2) pq.push_back({10'(h), 10'(v), rgb});
                if (bl) m_sum = m_sum + 16'(rgb[23:16]) + 16'(rgb[15:8]) + 16'(rgb[7:0]);
                if (clr) m_err = 0;
                if (hsf) begin
                    lines_since++;
                    if (short_pend) begin
                        short_pend = 0;
                        if (m_state != 0) begin m_state = 0; m_err = 1; end
                    end
                end
                if (vsf) begin
                    if (m_state == 0) m_state = 1;
                    else if (lines_since == VT) begin m_state = 2; cq.push_back(m_sum); end
                    else begin m_state = 1; m_err = 1; end
                    lines_since = 0;
                    m_sum = 0;
                end
                drive_pix(hs, vs, bl, rgb, clr);
            end
        end
        check_eq("pix_missing", pq.size(), 0);
        check_eq("done_missing", cq.size(), 0);
        pq.delete(); cq.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        gaps = 0;
        do_reset();

        // clean lock, constant and black checksums
        drive_frame(VT, -1, -1, 0, 0, 0);
        check_eq("no_lock_first_vs", locked, 0);
        drive_frame(VT, -1, -1, 0, 0, 0);
        check_eq("lock_second_vs", locked, 1);
        check_eq("const_checksum", checksum, 16'd960);
        drive_frame(VT, -1, -1, 0, 0, 0);
        drive_frame(VT, -1, -1, 1, 0, 0);
        check_eq("black_checksum", checksum, 16'd0);

        // short line, relock, sticky error then clear
        drive_frame(VT, 3, -1, 2, 0, 0);
        check_eq("short_line_err", sync_err, 1);
        drive_frame(VT, -1, -1, 2, 0, 0);
        drive_frame(VT, -1, -1, 2, 0, 0);
        check_eq("err_sticky", sync_err, 1);
        drive_frame(VT, -1, -1, 3, 1, 0);
        check_eq("err_cleared", sync_err, 0);

        // short frame with clear colliding with the violation
        drive_frame(VT - 1, -1, -1, 3, 0, 0);
        drive_frame(VT, -1, -1, 3, 0, 1);
        check_eq("clear_vs_violation", sync_err, 1);
        drive_frame(VT, -1, -1, 3, 0, 0);
        check_eq("relock_from_measure", locked, 1);

        // coordinate sweep with pix_en gaps
        gaps = 1;
        drive_frame(VT, -1, -1, 3, 0, 0);
        drive_frame(VT, -1, -1, 2, 0, 0);
        gaps = 0;

        // reset mid-frame
        drive_frame(VT, -1, 5, 3, 0, 0);
        drive_frame(VT, -1, -1, 3, 0, 0);
        drive_frame(VT, -1, -1, 3, 0, 0);
        check_eq("lock_after_reset", locked, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
